smartv_fault_log: RTL and testbench

SMARTV_FAULT_LOG -- requirements
Module: smartv_fault_log

---
 rtl/smartv_fault_log_if.sv | 45 ++++
 rtl/smartv_fault_log.sv | 155 +++++++++++++++
 tb/tb_smartv_fault_log.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/smartv_fault_log_if.sv
// Fault-log bus bundle between the protection unit / core controller side
// and the fault logger.
//   slave  : the fault logger (smartv_fault_log)
//   master : the protection unit, controller and log reader
// Signals:
//   data_err_i/data_addr_i/data_we_i    data-side error, held until acked
//   instr_fault_i/instr_addr_i          instruction-side fault, may pulse
//   data_err_ack_o                      one-cycle ack of a data capture
//   exc_req_o/exc_cause_o/exc_tval_o    exception request to controller
//   exc_ack_i                           controller accepts exception
//   log_rd_i/log_valid_o/log_cause_o/log_addr_o   log FIFO read side
//   fault_cnt_o/overflow_o/clear_i      statistics and their clear
interface smartv_fault_log_if;
    logic        data_err_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic        instr_fault_i;
    logic [31:0] instr_addr_i;
    logic        data_err_ack_o;
    logic        exc_req_o;
    logic [4:0]  exc_cause_o;
    logic [31:0] exc_tval_o;
    logic        exc_ack_i;
    logic        log_rd_i;
    logic        log_valid_o;
    logic [4:0]  log_cause_o;
    logic [31:0] log_addr_o;
    logic [15:0] fault_cnt_o;
    logic        overflow_o;
    logic        clear_i;

    modport slave (
        input  data_err_i, data_addr_i, data_we_i, instr_fault_i, instr_addr_i,
               exc_ack_i, log_rd_i, clear_i,
        output data_err_ack_o, exc_req_o, exc_cause_o, exc_tval_o,
               log_valid_o, log_cause_o, log_addr_o, fault_cnt_o, overflow_o
    );

    modport master (
        output data_err_i, data_addr_i, data_we_i, instr_fault_i, instr_addr_i,
               exc_ack_i, log_rd_i, clear_i,
        input  data_err_ack_o, exc_req_o, exc_cause_o, exc_tval_o,
               log_valid_o, log_cause_o, log_addr_o, fault_cnt_o, overflow_o
    );
endinterface

// File: rtl/smartv_fault_log.sv
// Protection fault logger: captures instruction / data protection faults,
// raises one exception at a time to the core controller, and records every
// capture in a small FIFO log with a saturating fault counter and a sticky
// overflow flag.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    smartv_fault_log_if.slave (fault inputs, exception and log outputs)
// Parameter:
//   LOG_DEPTH  number of log records (power of two, 2..16)
module smartv_fault_log #(
    parameter int LOG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    smartv_fault_log_if.slave bus
);
    localparam int PW = $clog2(LOG_DEPTH);

    typedef enum logic {IDLE, REPORT} state_t;
    typedef struct packed {
        logic [4:0]  cause;
        logic [31:0] addr;
    } rec_t;

    state_t        r_state;
    logic          r_ipend;
    logic [31:0]   r_ipend_addr;
    logic          r_exc_req;
    logic          r_ack;
    logic [4:0]    r_cause;
    logic [31:0]   r_tval;
    rec_t          r_mem [LOG_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic [15:0]   r_fcnt;
    logic          r_ovf;

    logic w_idle, w_cap_p, w_cap_i, w_cap_d, w_cap;
    logic w_ipend_set, w_ipend_drop;
    logic w_full, w_pop, w_push, w_drop;
    rec_t w_rec;

    // Pending instruction fault is older than anything live, so it goes first;
    // a data error loses to any instruction fault and simply stays asserted.
    assign w_idle  = (r_state == IDLE);
    assign w_cap_p = w_idle & r_ipend;
    assign w_cap_i = w_idle & ~r_ipend & bus.instr_fault_i;
    assign w_cap_d = w_idle & ~r_ipend & ~bus.instr_fault_i & bus.data_err_i;
    assign w_cap   = w_cap_p | w_cap_i | w_cap_d;

    // An instr pulse that cannot be captured now parks in the pending slot.
    // In IDLE the slot is being emptied by its own capture, so it can refill.
    assign w_ipend_set  = bus.instr_fault_i & ((~w_idle & ~r_ipend) | (w_idle & r_ipend));
    assign w_ipend_drop = bus.instr_fault_i & ~w_idle & r_ipend;

    always_comb begin
        w_rec = '0;
        if (w_cap_p) begin
            w_rec.cause = 5'd1;
            w_rec.addr  = r_ipend_addr;
        end else if (w_cap_i) begin
            w_rec.cause = 5'd1;
            w_rec.addr  = bus.instr_addr_i;
        end else if (w_cap_d) begin
            w_rec.cause = bus.data_we_i ? 5'd7 : 5'd5;
            w_rec.addr  = bus.data_addr_i;
        end
    end

    assign w_full = (r_count == (PW+1)'(LOG_DEPTH));
    assign w_pop  = bus.log_rd_i & (r_count != '0);
    assign w_push = w_cap & (~w_full | w_pop);
    assign w_drop = w_cap & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ipend      <= 1'b0;
            r_ipend_addr <= '0;
            r_exc_req    <= 1'b0;
            r_ack        <= 1'b0;
            r_cause      <= '0;
            r_tval       <= '0;
        end else begin
            r_ack <= 1'b0;
            if (w_ipend_set) begin
                r_ipend      <= 1'b1;
                r_ipend_addr <= bus.instr_addr_i;
            end else if (w_cap_p) begin
                r_ipend <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_ack <= w_cap_d;
                    if (w_cap) begin
                        r_cause   <= w_rec.cause;
                        r_tval    <= w_rec.addr;
                        r_exc_req <= 1'b1;
                        r_state   <= REPORT;
                    end
                end
                REPORT: begin
                    if (bus.exc_ack_i) begin
                        r_exc_req <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_fcnt  <= '0;
            r_ovf   <= 1'b0;
        end else if (bus.clear_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_fcnt  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_cap && r_fcnt != 16'hFFFF) r_fcnt <= r_fcnt + 16'd1;
            if (w_drop || w_ipend_drop)      r_ovf  <= 1'b1;
        end
    end

    // Record storage needs no reset: outputs are masked while the log is empty.
    always_ff @(posedge clk) begin
        if (!bus.clear_i && w_push) r_mem[r_wptr] <= w_rec;
    end

    assign bus.data_err_ack_o = r_ack;
    assign bus.exc_req_o      = r_exc_req;
    assign bus.exc_cause_o    = r_cause;
    assign bus.exc_tval_o     = r_tval;
    assign bus.log_valid_o    = (r_count != '0);
    assign bus.log_cause_o    = bus.log_valid_o ? r_mem[r_rptr].cause : '0;
    assign bus.log_addr_o     = bus.log_valid_o ? r_mem[r_rptr].addr  : '0;
    assign bus.fault_cnt_o    = r_fcnt;
    assign bus.overflow_o     = r_ovf;
endmodule

// File: tb/tb_smartv_fault_log.sv
module tb_smartv_fault_log;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    smartv_fault_log_if u_if();
    smartv_fault_log #(.LOG_DEPTH(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic zero_inputs();
        u_if.data_err_i = 0; u_if.data_addr_i = 0; u_if.data_we_i = 0;
        u_if.instr_fault_i = 0; u_if.instr_addr_i = 0;
        u_if.exc_ack_i = 0; u_if.log_rd_i = 0; u_if.clear_i = 0;
    endtask

    task automatic pop();
        u_if.log_rd_i = 1; tick(); u_if.log_rd_i = 0;
    endtask

    task automatic ack_exc();
        u_if.exc_ack_i = 1; tick(); u_if.exc_ack_i = 0;
    endtask

    task automatic do_clear();
        u_if.clear_i = 1; tick(); u_if.clear_i = 0;
    endtask

    task automatic test_reset();
        zero_inputs();
        rst_n = 0;
        #12;
        checks++; if ({u_if.exc_req_o, u_if.data_err_ack_o, u_if.log_valid_o, u_if.overflow_o} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {u_if.exc_req_o, u_if.data_err_ack_o, u_if.log_valid_o, u_if.overflow_o}); end
        checks++; if ({u_if.exc_cause_o, u_if.exc_tval_o, u_if.log_cause_o, u_if.log_addr_o, u_if.fault_cnt_o} !== 90'b0) begin failures++; $display("FAIL reset_values got nonzero cause=%0h tval=%0h lcause=%0h laddr=%0h cnt=%0h", u_if.exc_cause_o, u_if.exc_tval_o, u_if.log_cause_o, u_if.log_addr_o, u_if.fault_cnt_o); end
        @(posedge clk); #1; rst_n = 1;
        tick();
    endtask

    task automatic test_store();
        u_if.data_err_i = 1; u_if.data_we_i = 1; u_if.data_addr_i = 32'h0000_2000;
        tick();
        checks++; if (u_if.data_err_ack_o !== 1'b1) begin failures++; $display("FAIL store_ack got=%b exp=1", u_if.data_err_ack_o); end
        checks++; if (u_if.exc_req_o !== 1'b1) begin failures++; $display("FAIL store_req got=%b exp=1", u_if.exc_req_o); end
        checks++; if (u_if.exc_cause_o !== 5'd7) begin failures++; $display("FAIL store_cause got=%0d exp=7", u_if.exc_cause_o); end
        checks++; if (u_if.exc_tval_o !== 32'h2000) begin failures++; $display("FAIL store_tval got=%h exp=00002000", u_if.exc_tval_o); end
        u_if.data_err_i = 0;
        tick();
        checks++; if (u_if.data_err_ack_o !== 1'b0) begin failures++; $display("FAIL store_ack_once got=%b exp=0", u_if.data_err_ack_o); end
        checks++; if (u_if.exc_req_o !== 1'b1 || u_if.exc_cause_o !== 5'd7) begin failures++; $display("FAIL store_hold req=%b cause=%0d exp req=1 cause=7", u_if.exc_req_o, u_if.exc_cause_o); end
        ack_exc();
        checks++; if (u_if.exc_req_o !== 1'b0) begin failures++; $display("FAIL store_idle got=%b exp=0", u_if.exc_req_o); end
        checks++; if (u_if.log_valid_o !== 1'b1 || u_if.log_cause_o !== 5'd7 || u_if.log_addr_o !== 32'h2000) begin failures++; $display("FAIL store_log got v=%b c=%0d a=%h exp v=1 c=7 a=00002000", u_if.log_valid_o, u_if.log_cause_o, u_if.log_addr_o); end
        checks++; if (u_if.fault_cnt_o !== 16'd1) begin failures++; $display("FAIL store_cnt got=%0d exp=1", u_if.fault_cnt_o); end
        pop();
        checks++; if (u_if.log_valid_o !== 1'b0) begin failures++; $display("FAIL store_pop got=%b exp=0", u_if.log_valid_o); end
    endtask

    task automatic test_simultaneous();
        do_clear();
        u_if.instr_fault_i = 1; u_if.instr_addr_i = 32'h100;
        u_if.data_err_i = 1; u_if.data_we_i = 0; u_if.data_addr_i = 32'h0080_0400;
        tick();
        u_if.instr_fault_i = 0;
        checks++; if (u_if.exc_cause_o !== 5'd1 || u_if.exc_tval_o !== 32'h100) begin failures++; $display("FAIL simul_first got c=%0d t=%h exp c=1 t=00000100", u_if.exc_cause_o, u_if.exc_tval_o); end
        checks++; if (u_if.data_err_ack_o !== 1'b0) begin failures++; $display("FAIL simul_noack got=%b exp=0", u_if.data_err_ack_o); end
        ack_exc();
        checks++; if (u_if.exc_req_o !== 1'b0) begin failures++; $display("FAIL simul_idle got=%b exp=0", u_if.exc_req_o); end
        tick();
        checks++; if (u_if.exc_cause_o !== 5'd5 || u_if.exc_tval_o !== 32'h0080_0400 || u_if.data_err_ack_o !== 1'b1) begin failures++; $display("FAIL simul_second got c=%0d t=%h ack=%b exp c=5 t=00800400 ack=1", u_if.exc_cause_o, u_if.exc_tval_o, u_if.data_err_ack_o); end
        u_if.data_err_i = 0;
        ack_exc();
        checks++; if (u_if.fault_cnt_o !== 16'd2) begin failures++; $display("FAIL simul_cnt got=%0d exp=2", u_if.fault_cnt_o); end
        checks++; if (u_if.log_cause_o !== 5'd1 || u_if.log_addr_o !== 32'h100) begin failures++; $display("FAIL simul_log0 got c=%0d a=%h exp c=1 a=00000100", u_if.log_cause_o, u_if.log_addr_o); end
        pop();
        checks++; if (u_if.log_cause_o !== 5'd5 || u_if.log_addr_o !== 32'h0080_0400) begin failures++; $display("FAIL simul_log1 got c=%0d a=%h exp c=5 a=00800400", u_if.log_cause_o, u_if.log_addr_o); end
        pop();
        checks++; if (u_if.log_valid_o !== 1'b0) begin failures++; $display("FAIL simul_empty got=%b exp=0", u_if.log_valid_o); end
    endtask

    task automatic test_pending();
        do_clear();
        u_if.instr_fault_i = 1; u_if.instr_addr_i = 32'h10;
        tick();
        u_if.instr_addr_i = 32'h200;
        tick();
        u_if.instr_fault_i = 0;
        checks++; if (u_if.overflow_o !== 1'b0) begin failures++; $display("FAIL pend_noovf got=%b exp=0", u_if.overflow_o); end
        tick();
        u_if.instr_fault_i = 1; u_if.instr_addr_i = 32'h300;
        tick();
        u_if.instr_fault_i = 0;
        checks++; if (u_if.overflow_o !== 1'b1) begin failures++; $display("FAIL pend_ovf got=%b exp=1", u_if.overflow_o); end
        checks++; if (u_if.exc_tval_o !== 32'h10) begin failures++; $display("FAIL pend_stable got=%h exp=00000010", u_if.exc_tval_o); end
        ack_exc();
        checks++; if (u_if.exc_req_o !== 1'b0) begin failures++; $display("FAIL pend_idle got=%b exp=0", u_if.exc_req_o); end
        tick();
        checks++; if (u_if.exc_req_o !== 1'b1 || u_if.exc_cause_o !== 5'd1 || u_if.exc_tval_o !== 32'h200) begin failures++; $display("FAIL pend_report got r=%b c=%0d t=%h exp r=1 c=1 t=00000200", u_if.exc_req_o, u_if.exc_cause_o, u_if.exc_tval_o); end
        ack_exc();
        tick();
        checks++; if (u_if.exc_req_o !== 1'b0 || u_if.fault_cnt_o !== 16'd2) begin failures++; $display("FAIL pend_dropped got r=%b cnt=%0d exp r=0 cnt=2", u_if.exc_req_o, u_if.fault_cnt_o); end
        pop();
        checks++; if (u_if.log_addr_o !== 32'h200) begin failures++; $display("FAIL pend_log got=%h exp=00000200", u_if.log_addr_o); end
        pop();
    endtask

    task automatic test_overflow();
        do_clear();
        for (int k = 0; k < 5; k++) begin
            u_if.instr_fault_i = 1; u_if.instr_addr_i = 32'h1000 + 32'(k * 4);
            tick();
            u_if.instr_fault_i = 0;
            ack_exc();
            if (k == 3) begin
                checks++; if (u_if.overflow_o !== 1'b0) begin failures++; $display("FAIL ovf_full_noovf got=%b exp=0", u_if.overflow_o); end
            end
        end
        checks++; if (u_if.overflow_o !== 1'b1 || u_if.fault_cnt_o !== 16'd5) begin failures++; $display("FAIL ovf_set got ovf=%b cnt=%0d exp ovf=1 cnt=5", u_if.overflow_o, u_if.fault_cnt_o); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (u_if.log_valid_o !== 1'b1 || u_if.log_addr_o !== 32'h1000 + 32'(k * 4)) begin failures++; $display("FAIL ovf_keep%0d got v=%b a=%h exp a=%h", k, u_if.log_valid_o, u_if.log_addr_o, 32'h1000 + 32'(k * 4)); end
            pop();
        end
        checks++; if (u_if.log_valid_o !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0", u_if.log_valid_o); end
        do_clear();
        for (int k = 0; k < 4; k++) begin
            u_if.instr_fault_i = 1; u_if.instr_addr_i = 32'h1000 + 32'(k * 4);
            tick();
            u_if.instr_fault_i = 0;
            ack_exc();
        end
        u_if.instr_fault_i = 1; u_if.instr_addr_i = 32'h2000; u_if.log_rd_i = 1;
        tick();
        u_if.instr_fault_i = 0; u_if.log_rd_i = 0;
        checks++; if (u_if.overflow_o !== 1'b0 || u_if.log_addr_o !== 32'h1004) begin failures++; $display("FAIL pushpop got ovf=%b head=%h exp ovf=0 head=00001004", u_if.overflow_o, u_if.log_addr_o); end
        ack_exc();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_a;
            exp_a = (k < 3) ? 32'h1004 + 32'(k * 4) : 32'h2000;
            checks++; if (u_if.log_addr_o !== exp_a) begin failures++; $display("FAIL pushpop_rec%0d got=%h exp=%h", k, u_if.log_addr_o, exp_a); end
            pop();
        end
        pop();
        checks++; if (u_if.log_valid_o !== 1'b0) begin failures++; $display("FAIL empty_pop got=%b exp=0", u_if.log_valid_o); end
        u_if.instr_fault_i = 1; u_if.instr_addr_i = 32'h4444;
        tick();
        u_if.instr_fault_i = 0;
        checks++; if (u_if.log_valid_o !== 1'b1 || u_if.log_addr_o !== 32'h4444) begin failures++; $display("FAIL after_empty_pop got v=%b a=%h exp v=1 a=00004444", u_if.log_valid_o, u_if.log_addr_o); end
        ack_exc();
        pop();
    endtask

    task automatic test_clear_reset();
        do_clear();
        u_if.instr_fault_i = 1; u_if.instr_addr_i = 32'h40;
        tick();
        u_if.instr_addr_i = 32'h50;
        tick();
        u_if.instr_addr_i = 32'h60;
        tick();
        u_if.instr_fault_i = 0;
        checks++; if (u_if.overflow_o !== 1'b1) begin failures++; $display("FAIL clr_pre_ovf got=%b exp=1", u_if.overflow_o); end
        ack_exc();
        u_if.clear_i = 1;
        tick();
        u_if.clear_i = 0;
        checks++; if (u_if.exc_req_o !== 1'b1 || u_if.exc_tval_o !== 32'h50) begin failures++; $display("FAIL clr_exc got r=%b t=%h exp r=1 t=00000050", u_if.exc_req_o, u_if.exc_tval_o); end
        checks++; if (u_if.log_valid_o !== 1'b0 || u_if.fault_cnt_o !== 16'd0 || u_if.overflow_o !== 1'b0) begin failures++; $display("FAIL clr_state got v=%b cnt=%0d ovf=%b exp 0 0 0", u_if.log_valid_o, u_if.fault_cnt_o, u_if.overflow_o); end
        u_if.data_err_i = 1; u_if.data_we_i = 1; u_if.data_addr_i = 32'h3000;
        rst_n = 0;
        #2;
        checks++; if ({u_if.exc_req_o, u_if.data_err_ack_o, u_if.log_valid_o, u_if.overflow_o, u_if.exc_cause_o, u_if.exc_tval_o, u_if.fault_cnt_o} !== 57'b0) begin failures++; $display("FAIL rst_mid got r=%b c=%0d t=%h cnt=%0d exp all 0", u_if.exc_req_o, u_if.exc_cause_o, u_if.exc_tval_o, u_if.fault_cnt_o); end
        tick();
        rst_n = 1;
        tick();
        checks++; if (u_if.exc_req_o !== 1'b1 || u_if.exc_cause_o !== 5'd7 || u_if.exc_tval_o !== 32'h3000 || u_if.data_err_ack_o !== 1'b1) begin failures++; $display("FAIL rst_recapture got r=%b c=%0d t=%h ack=%b exp r=1 c=7 t=00003000 ack=1", u_if.exc_req_o, u_if.exc_cause_o, u_if.exc_tval_o, u_if.data_err_ack_o); end
        checks++; if (u_if.fault_cnt_o !== 16'd1) begin failures++; $display("FAIL rst_cnt got=%0d exp=1", u_if.fault_cnt_o); end
        u_if.data_err_i = 0;
        ack_exc();
    endtask

    initial begin
        test_reset();
        test_store();
        test_simultaneous();
        test_pending();
        test_overflow();
        test_clear_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
